// File: rtl/uart_control_pkg.sv
// Shared constants, field positions, FSM encodings and the frame byte
// builder for the UART control-frame transmitter.
package uart_control_pkg;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;
    localparam logic [7:0] TAIL  = 8'h55;
    localparam int FRAME_BYTES   = 6;

    localparam int BAUD_MSB   = 11;
    localparam int BAUD_LSB   = 8;
    localparam int WIDTH_MSB  = 5;
    localparam int WIDTH_LSB  = 4;
    localparam int STOP_MSB   = 3;
    localparam int STOP_LSB   = 2;
    localparam int PARITY_MSB = 1;
    localparam int PARITY_LSB = 0;

    // Bit-level states of the byte serializer
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} tx_state_t;

    // Frame-level states of the byte sequencer
    typedef enum logic [1:0] {Q_IDLE, Q_BYTE, Q_GAP} seq_state_t;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] word);
        case (idx)
            3'd0:    return SYNC0;
            3'd1:    return SYNC1;
            3'd2:    return word[15:8];
            3'd3:    return word[7:0];
            3'd4:    return word[15:8] + word[7:0];
            default: return TAIL;
        endcase
    endfunction

endpackage

// File: rtl/uart_control_tx_if.sv
// Control/status bundle between the frame source and the transmitter.
interface uart_control_tx_if;
    logic        bps_en;
    logic [15:0] control_word;
    logic        send;
    logic        control_tx;
    logic        busy;
    logic        done;

    modport master (output bps_en, control_word, send, input control_tx, busy, done);
    modport slave  (input bps_en, control_word, send, output control_tx, busy, done);
endinterface

// File: rtl/uart_control_tx_byte.sv
// 8N1 LSB-first byte serializer. ready is high when a load this cycle is
// taken, including the final tick of a stop bit so bytes can abut.
module uart_control_tx_byte
    import uart_control_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bps_en,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    tx_state_t     state_reg;
    logic [TW-1:0] tick_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          bit_end;

    assign bit_end = bps_en && (tick_cnt_reg == TW'(OVERSAMPLE - 1));
    assign ready   = (state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end);
    assign tx      = tx_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else if (load && ready) begin
            state_reg    <= S_START;
            shift_reg    <= data;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            tx_reg <= 1'b1;
        end else if (bit_end) begin
            // Level of the next bit is driven from the cycle after the last tick
            tick_cnt_reg <= '0;
            case (state_reg)
                S_START: begin
                    state_reg   <= S_DATA;
                    bit_cnt_reg <= 3'd0;
                    tx_reg      <= shift_reg[0];
                end
                S_DATA: begin
                    if (bit_cnt_reg == 3'd7) begin
                        state_reg <= S_STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        tx_reg      <= shift_reg[bit_cnt_reg + 3'd1];
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end else if (bps_en) begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end
endmodule

// File: rtl/uart_control_tx.sv
// Control-frame transmitter: sequences AA 55 hi lo sum 55 through the byte
// serializer, with optional idle gap between bytes and busy/done status.
module uart_control_tx
    import uart_control_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int GAP_BITS   = 1
) (
    input  logic             clock,
    input  logic             reset,
    uart_control_tx_if.slave bus
);
    localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
    localparam int GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    seq_state_t    state_reg;
    logic [2:0]    byte_idx_reg;
    logic [15:0]   word_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          busy_reg;
    logic          done_reg;

    logic          accept;
    logic          gap_end;
    logic          byte_end;
    logic          last_byte;
    logic          ser_load;
    logic          ser_ready;
    logic [2:0]    next_idx;
    logic [7:0]    ser_data;

    assign accept    = (state_reg == Q_IDLE) && bus.send;
    assign gap_end   = (state_reg == Q_GAP) && bus.bps_en && (gap_cnt_reg == GW'(GAP_TICKS - 1));
    assign byte_end  = (state_reg == Q_BYTE) && ser_ready;
    assign last_byte = (byte_idx_reg == 3'(FRAME_BYTES - 1));
    // With no gap the next start bit must follow the stop bit's last tick directly
    assign ser_load  = accept || gap_end || (byte_end && !last_byte && (GAP_BITS == 0));
    assign next_idx  = accept ? 3'd0 : byte_idx_reg + 3'd1;
    assign ser_data  = frame_byte(next_idx, word_reg);

    uart_control_tx_byte #(.OVERSAMPLE(OVERSAMPLE)) u_byte (
        .clock  (clock),
        .reset  (reset),
        .bps_en (bus.bps_en),
        .load   (ser_load),
        .data   (ser_data),
        .ready  (ser_ready),
        .tx     (bus.control_tx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= Q_IDLE;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            gap_cnt_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                Q_IDLE: begin
                    if (bus.send) begin
                        word_reg     <= bus.control_word;
                        byte_idx_reg <= 3'd0;
                        busy_reg     <= 1'b1;
                        state_reg    <= Q_BYTE;
                    end
                end
                Q_BYTE: begin
                    if (ser_ready) begin
                        if (last_byte) begin
                            state_reg <= Q_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else if (GAP_BITS > 0) begin
                            state_reg   <= Q_GAP;
                            gap_cnt_reg <= '0;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    if (gap_end) begin
                        byte_idx_reg <= byte_idx_reg + 3'd1;
                        gap_cnt_reg  <= '0;
                        state_reg    <= Q_BYTE;
                    end else if (bus.bps_en) begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_uart_control_tx.sv
// Bench for uart_control_tx: tick-level waveform and byte decode against a
// frame model, plus reset, mid-frame and back-to-back corner cases.
module tb_uart_control_tx;

    typedef bit bitq_t[$];
    typedef struct {
        logic [15:0] word;
        logic [7:0]  chk;
        int          mode;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset_b = 1'b1;
    always #5 clock = ~clock;

    uart_control_tx_if if_a();
    uart_control_tx_if if_b();

    uart_control_tx #(.OVERSAMPLE(16), .GAP_BITS(1)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a.slave));
    uart_control_tx #(.OVERSAMPLE(16), .GAP_BITS(0)) dut_b (
        .clock (clock), .reset (reset_b), .bus (if_b.slave));

    int vectors = 0;
    int miscompares = 0;
    int bps_mode = 0;
    int div = 0;
    int done_a = 0;
    int frames_b = 0;
    int run_b = 0;
    bitq_t cap_a;
    bitq_t cap_b;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    function automatic int model_byte(input logic [15:0] w, input int k);
        int hi = int'(w[15:8]);
        int lo = int'(w[7:0]);
        case (k)
            0: return 170;
            1: return 85;
            2: return hi;
            3: return lo;
            4: return (hi + lo) % 256;
            default: return 85;
        endcase
    endfunction

    // Line level at every baud tick of a whole frame
    function automatic bitq_t model_wave(input logic [15:0] w, input int gap);
        bitq_t q;
        for (int k = 0; k < 6; k++) begin
            int b = model_byte(w, k);
            for (int t = 0; t < 16; t++) q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int t = 0; t < 16; t++) q.push_back(bit'((b >> i) & 1));
            for (int t = 0; t < 16; t++) q.push_back(1'b1);
            if (k < 5)
                for (int t = 0; t < gap * 16; t++) q.push_back(1'b1);
        end
        return q;
    endfunction

    function automatic int wave_diff(input bitq_t a, input bitq_t b);
        int n = 0;
        int lim = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < lim; i++) if (a[i] != b[i]) n++;
        return n + ((a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size());
    endfunction

    function automatic int decode_byte(input bitq_t q, input int k, input int gap);
        int base = k * (160 + gap * 16);
        int v = 0;
        if (base + 160 > q.size()) return -1;
        for (int i = 0; i < 8; i++) v |= int'(q[base + 16 * (1 + i) + 8]) << i;
        return v;
    endfunction

    always @(posedge clock) begin
        #1;
        div++;
        case (bps_mode)
            0:       if_a.bps_en = (div % 4 == 0);
            1:       if_a.bps_en = ($urandom_range(0, 2) == 0);
            default: if_a.bps_en = 1'b0;
        endcase
    end

    always @(negedge clock) begin
        if (if_a.busy && if_a.bps_en) cap_a.push_back(if_a.control_tx);
        if (if_a.done) begin
            done_a++;
            check("done_a_not_busy", int'(if_a.busy), 0);
        end
    end

    always @(negedge clock) begin
        if (if_b.busy) begin
            run_b++;
            cap_b.push_back(if_b.control_tx);
        end else if (run_b > 0) begin
            check("b2b_busy_clocks", run_b, 960);
            check("b2b_wave_diff", wave_diff(cap_b, model_wave(16'hC3A5, 0)), 0);
            check("b2b_checksum", decode_byte(cap_b, 4, 0), model_byte(16'hC3A5, 4));
            frames_b++;
            run_b = 0;
            cap_b.delete();
        end
        if (if_b.done) check("done_b_not_busy", int'(if_b.busy), 0);
    end

    task automatic start_frame(input logic [15:0] w);
        @(posedge clock); #1;
        if_a.control_word = w;
        cap_a.delete();
        if_a.send = 1'b1;
        @(posedge clock); #1;
        if_a.send = 1'b0;
        @(negedge clock);
        check("accept_busy", int'(if_a.busy), 1);
        check("accept_line", int'(if_a.control_tx), 0);
    endtask

    task automatic finish_frame(input logic [15:0] w, input int exp_chk, input int d0);
        bitq_t exp_q;
        bit seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clock);
            if (if_a.done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        exp_q = model_wave(w, 1);
        check("frame_ticks", cap_a.size(), 1040);
        check("wave_diff", wave_diff(cap_a, exp_q), 0);
        for (int k = 0; k < 6; k++)
            check($sformatf("byte%0d", k), decode_byte(cap_a, k, 1), model_byte(w, k));
        if (exp_chk >= 0) check("table_checksum", decode_byte(cap_a, 4, 1), exp_chk);
        repeat (3) @(negedge clock);
        check("single_done", done_a - d0, 1);
    endtask

    task automatic wait_ticks(input int target);
        for (int c = 0; c < 20000 && cap_a.size() < target; c++) @(negedge clock);
        check("reach_tick", int'(cap_a.size() >= target), 1);
    endtask

    initial begin
        vec_t tbl[4];
        int d0;
        int busy_cnt;
        logic [15:0] w;

        tbl[0] = '{word: 16'h0634, chk: 8'h3A, mode: 0};
        tbl[1] = '{word: 16'hF0F0, chk: 8'hE0, mode: 0};
        tbl[2] = '{word: 16'hFF01, chk: 8'h00, mode: 1};
        tbl[3] = '{word: 16'h0D30, chk: 8'h3D, mode: 1};

        if_a.bps_en = 1'b0;
        if_a.send = 1'b0;
        if_a.control_word = 16'h0000;
        if_b.bps_en = 1'b1;
        if_b.send = 1'b1;
        if_b.control_word = 16'hC3A5;

        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if_a.send = i[0];
            @(negedge clock);
            check("rst_line", int'(if_a.control_tx), 1);
            check("rst_busy_done", int'({if_a.busy, if_a.done}), 0);
        end
        @(posedge clock); #1;
        if_a.send = 1'b0;
        reset = 1'b0;
        reset_b = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_line", int'(if_a.control_tx), 1);
        end

        foreach (tbl[i]) begin
            bps_mode = tbl[i].mode;
            d0 = done_a;
            start_frame(tbl[i].word);
            finish_frame(tbl[i].word, int'(tbl[i].chk), d0);
        end

        for (int r = 0; r < 3; r++) begin
            w = 16'($urandom);
            bps_mode = r % 2;
            d0 = done_a;
            start_frame(w);
            finish_frame(w, -1, d0);
        end

        bps_mode = 0;
        d0 = done_a;
        start_frame(16'h5A3C);
        wait_ticks(2 * 176 + 20);
        @(posedge clock); #1;
        if_a.send = 1'b1;
        if_a.control_word = 16'h0000;
        @(posedge clock); #1;
        if_a.send = 1'b0;
        finish_frame(16'h5A3C, -1, d0);
        busy_cnt = 0;
        repeat (300) begin
            @(negedge clock);
            if (if_a.busy) busy_cnt++;
        end
        check("no_second_frame", busy_cnt, 0);

        d0 = done_a;
        start_frame(16'h1357);
        wait_ticks(3 * 176 + 16 + 40);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("abort_line", int'(if_a.control_tx), 1);
        check("abort_busy", int'(if_a.busy), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("abort_no_done", done_a - d0, 0);
        d0 = done_a;
        start_frame(16'h0D30);
        finish_frame(16'h0D30, 8'h3D, d0);

        for (int c = 0; c < 20000 && frames_b < 3; c++) @(negedge clock);
        check("b2b_frames", int'(frames_b >= 3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
